// File: rtl/cpu_pkg.sv
// Shared definitions for the program-counter / status-flag unit.
//   pc_state_e        : sequencing FSM states (RUN, FLUSH, HALT)
//   FLAG_*            : bit positions of the ALU flags inside the flag register
//   DEFAULT_RESET_PC  : default PC loaded on reset
//   RAS_DEPTH         : return-address stack depth (only used when
//                       PC_STATUS_CALL_STACK_EN is defined)
package cpu_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_HALT  = 2'd2
    } pc_state_e;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    localparam int FLAG_Z    = 0;
    localparam int FLAG_N    = 1;
    localparam int FLAG_C    = 2;
    localparam int FLAG_V    = 3;
    localparam int FLAG_H    = 4;
    localparam int NUM_FLAGS = 5;

    localparam int RAS_DEPTH = 4;

endpackage

// File: rtl/ret_addr_stack.sv
// Return-address stack, DEPTH entries (DEPTH must be a power of two).
// Implemented as a circular buffer so a push onto a full stack silently
// overwrites the oldest entry. A pop on an empty stack leaves it empty and
// 'data' reads EMPTY_VAL while empty.
// Ports:
//   clk, rst   : clock, synchronous active-high reset (clears occupancy)
//   push       : write push_data as the new top
//   pop        : discard the top entry (push wins if both asserted)
//   push_data  : address to push
//   full/empty : occupancy status
//   data       : current top entry (EMPTY_VAL when empty)
module ret_addr_stack
    import cpu_pkg::*;
#(
    parameter int          DEPTH     = RAS_DEPTH,
    parameter logic [31:0] EMPTY_VAL = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic        pop,
    input  logic [31:0] push_data,
    output logic        full,
    output logic        empty,
    output logic [31:0] data
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [31:0]   mem_q [DEPTH];
    logic [31:0]   mem_d [DEPTH];
    logic [PW-1:0] top_q, top_d;
    logic [CW-1:0] cnt_q, cnt_d;

    assign full  = (cnt_q == CW'(DEPTH));
    assign empty = (cnt_q == '0);
    assign data  = empty ? EMPTY_VAL : mem_q[top_q];

    always_comb begin
        mem_d = mem_q;
        top_d = top_q;
        cnt_d = cnt_q;
        if (push) begin
            // Pointer wraps, so when full the slot written is the oldest one.
            top_d        = top_q + PW'(1);
            mem_d[top_d] = push_data;
            if (!full) cnt_d = cnt_q + CW'(1);
        end else if (pop && !empty) begin
            top_d = top_q - PW'(1);
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            top_q <= '0;
            cnt_q <= '0;
        end else begin
            top_q <= top_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage needs no reset: entries are only visible while counted.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/pc_status_unit.sv
// Program counter sequencing and ALU status-flag register.
// Optional feature macro: PC_STATUS_CALL_STACK_EN adds a 4-entry
// return-address stack (call pushes pc+PC_INC, ret pops into pc). Without it
// call acts as a plain branch and ret is ignored.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   ex_valid              : ALU result valid this cycle
//   stall                 : freeze pc, state, flush counter and flags
//   alu_out, branch       : branch target / branch taken
//   flag_we, z/n/c/v/h_in : flag latch enable and ALU flags
//   halt, call, ret       : stop fetch, subroutine call / return
//   pc, flush             : fetch address, squash fetch/decode
//   zout..hout, sout      : registered flags, sout = nout ^ vout
//   halted                : in HALT state
module pc_status_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = DEFAULT_RESET_PC,
    parameter int          PC_INC       = 1,
    parameter int          FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic        stall,
    input  logic [31:0] alu_out,
    input  logic        branch,
    input  logic        flag_we,
    input  logic        z_in,
    input  logic        n_in,
    input  logic        c_in,
    input  logic        v_in,
    input  logic        h_in,
    input  logic        halt,
    input  logic        call,
    input  logic        ret,
    output logic [31:0] pc,
    output logic        flush,
    output logic        zout,
    output logic        nout,
    output logic        cout,
    output logic        vout,
    output logic        hout,
    output logic        sout,
    output logic        halted
);

    localparam logic [31:0] PC_STEP    = 32'(PC_INC);
    localparam logic [1:0]  FLUSH_LAST = 2'(FLUSH_CYCLES - 1);

    pc_state_e              state_q, state_d;
    logic [31:0]            pc_q, pc_d;
    logic [1:0]             fcnt_q, fcnt_d;
    logic [NUM_FLAGS-1:0]   flags_q, flags_d;

    logic                   take_br;
    logic                   do_ret;
    logic                   ras_push;
    logic                   ras_pop;
    logic [31:0]            ras_data;

`ifdef PC_STATUS_CALL_STACK_EN
    logic ras_full_unused;
    logic ras_empty_unused;

    assign take_br = branch | call;
    assign do_ret  = ret;

    ret_addr_stack #(
        .DEPTH     (RAS_DEPTH),
        .EMPTY_VAL (RESET_PC)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (pc_q + PC_STEP),
        .full      (ras_full_unused),
        .empty     (ras_empty_unused),
        .data      (ras_data)
    );
`else
    logic ras_unused;

    assign take_br    = branch | call;
    assign do_ret     = 1'b0;
    assign ras_data   = RESET_PC;
    assign ras_unused = ^{ret, ras_push, ras_pop};
`endif

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        fcnt_d   = fcnt_q;
        flags_d  = flags_q;
        ras_push = 1'b0;
        ras_pop  = 1'b0;
        if (!stall) begin
            case (state_q)
                ST_RUN: begin
                    if (ex_valid && flag_we) begin
                        flags_d[FLAG_Z] = z_in;
                        flags_d[FLAG_N] = n_in;
                        flags_d[FLAG_C] = c_in;
                        flags_d[FLAG_V] = v_in;
                        flags_d[FLAG_H] = h_in;
                    end
                    if (halt) begin
                        state_d = ST_HALT;
                    end else if (ex_valid) begin
                        if (take_br) begin
                            pc_d     = alu_out;
                            state_d  = ST_FLUSH;
                            fcnt_d   = '0;
                            ras_push = call;
                        end else if (do_ret) begin
                            pc_d    = ras_data;
                            ras_pop = 1'b1;
                            state_d = ST_FLUSH;
                            fcnt_d  = '0;
                        end else begin
                            pc_d = pc_q + PC_STEP;
                        end
                    end
                end
                ST_FLUSH: begin
                    // Bubbles still advance the fetch address.
                    if (halt) begin
                        state_d = ST_HALT;
                    end else begin
                        pc_d = pc_q + PC_STEP;
                        if (fcnt_q == FLUSH_LAST) begin
                            state_d = ST_RUN;
                            fcnt_d  = '0;
                        end else begin
                            fcnt_d = fcnt_q + 2'd1;
                        end
                    end
                end
                default: ; // HALT: only reset leaves
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_PC;
            fcnt_q  <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            fcnt_q  <= fcnt_d;
            flags_q <= flags_d;
        end
    end

    assign pc     = pc_q;
    assign flush  = (state_q == ST_FLUSH);
    assign halted = (state_q == ST_HALT);
    assign zout   = flags_q[FLAG_Z];
    assign nout   = flags_q[FLAG_N];
    assign cout   = flags_q[FLAG_C];
    assign vout   = flags_q[FLAG_V];
    assign hout   = flags_q[FLAG_H];
    assign sout   = flags_q[FLAG_N] ^ flags_q[FLAG_V];

endmodule

// File: tb/tb_pc_status_unit.sv
module tb_pc_status_unit;

    localparam logic [31:0] RESET_PC     = 32'h0;
    localparam int          PC_INC       = 1;
    localparam int          FLUSH_CYCLES = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ex_valid = 1'b0, stall = 1'b0, branch = 1'b0, flag_we = 1'b0;
    logic [31:0] alu_out = '0;
    logic        z_in = 1'b0, n_in = 1'b0, c_in = 1'b0, v_in = 1'b0, h_in = 1'b0;
    logic        halt = 1'b0, call = 1'b0, ret = 1'b0;
    logic [31:0] pc;
    logic        flush, zout, nout, cout, vout, hout, sout, halted;

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    pc_status_unit #(
        .RESET_PC(RESET_PC), .PC_INC(PC_INC), .FLUSH_CYCLES(FLUSH_CYCLES)
    ) dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .stall(stall),
        .alu_out(alu_out), .branch(branch), .flag_we(flag_we),
        .z_in(z_in), .n_in(n_in), .c_in(c_in), .v_in(v_in), .h_in(h_in),
        .halt(halt), .call(call), .ret(ret),
        .pc(pc), .flush(flush), .zout(zout), .nout(nout), .cout(cout),
        .vout(vout), .hout(hout), .sout(sout), .halted(halted)
    );

    // Behavioural model: mode 0=running, 1=flushing, 2=halted.
    int          m_mode = 0;
    int          m_left = 0;
    logic [31:0] m_pc = '0;
    logic        m_z = 0, m_n = 0, m_c = 0, m_v = 0, m_h = 0;
    logic [31:0] m_stk[$];

    always @(posedge clk) begin
        if (rst) begin
            m_pc = RESET_PC; m_mode = 0; m_left = 0;
            {m_z, m_n, m_c, m_v, m_h} = '0;
            m_stk.delete();
        end else if (!stall) begin
            if (m_mode == 0) begin
                if (ex_valid && flag_we) {m_z, m_n, m_c, m_v, m_h} = {z_in, n_in, c_in, v_in, h_in};
                if (halt) m_mode = 2;
                else if (ex_valid) begin
                    if (branch || call) begin
`ifdef PC_STATUS_CALL_STACK_EN
                        if (call) begin
                            if (m_stk.size() == 4) void'(m_stk.pop_front());
                            m_stk.push_back(m_pc + PC_INC);
                        end
`endif
                        m_pc = alu_out; m_mode = 1; m_left = FLUSH_CYCLES;
                    end
`ifdef PC_STATUS_CALL_STACK_EN
                    else if (ret) begin
                        m_pc = (m_stk.size() == 0) ? RESET_PC : m_stk.pop_back();
                        m_mode = 1; m_left = FLUSH_CYCLES;
                    end
`endif
                    else m_pc = m_pc + PC_INC;
                end
            end else if (m_mode == 1) begin
                if (halt) m_mode = 2;
                else begin
                    m_pc = m_pc + PC_INC;
                    m_left--;
                    if (m_left == 0) m_mode = 0;
                end
            end
        end
    end

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        logic [39:0] act, exp;
        if (chk_en) begin
            act = {pc, flush, halted, zout, nout, cout, vout, hout, sout};
            exp = {m_pc, m_mode == 1, m_mode == 2, m_z, m_n, m_c, m_v, m_h, m_n ^ m_v};
            n_chk++;
            if (act !== exp) begin
                n_err++;
                $display("FAIL cycle_compare t=%0t act{pc,fl,hl,znCvhs}=%h exp=%h", $time, act, exp);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle();
        ex_valid = 0; stall = 0; branch = 0; flag_we = 0; halt = 0;
        call = 0; ret = 0; rst = 0; alu_out = '0;
        {z_in, n_in, c_in, v_in, h_in} = '0;
    endtask

`ifdef PC_STATUS_CALL_STACK_EN
    logic [31:0] ret_exp [5];
`endif

    initial begin
        // Reset
        rst = 1; tick(); tick();
        check("reset_pc", pc, RESET_PC);
        check("reset_flush", {31'b0, flush}, 32'd0);
        check("reset_halted", {31'b0, halted}, 32'd0);
        check("reset_flags", {26'b0, zout, nout, cout, vout, hout, sout}, 32'd0);
        idle(); chk_en = 1;

        // Sequential increment
        ex_valid = 1;
        tick(); check("inc_1", pc, 32'd1);
        tick(); check("inc_2", pc, 32'd2);
        tick(); check("inc_3", pc, 32'd3);
        check("inc_flush", {31'b0, flush}, 32'd0);
        tick(); tick(); check("inc_5", pc, 32'd5);

        // Branch and two flush cycles; flag_we during flush ignored
        branch = 1; alu_out = 32'h40;
        tick(); check("br_pc", pc, 32'h40); check("br_flush1", {31'b0, flush}, 32'd1);
        branch = 0; flag_we = 1; z_in = 1; n_in = 1;
        tick(); check("fl2_pc", pc, 32'h41); check("br_flush2", {31'b0, flush}, 32'd1);
        tick(); check("fl_end_pc", pc, 32'h42); check("fl_end_flush", {31'b0, flush}, 32'd0);
        check("fl_flags_held", {31'b0, zout}, 32'd0);
        idle();

        // Flag latch, then stall holds
        ex_valid = 1; flag_we = 1; n_in = 1; v_in = 0; z_in = 1;
        tick(); check("flag_n", {31'b0, nout}, 32'd1); check("flag_z", {31'b0, zout}, 32'd1);
        check("flag_s", {31'b0, sout}, 32'd1); check("flag_pc", pc, 32'h43);
        stall = 1; n_in = 0; z_in = 0; v_in = 1; c_in = 1;
        tick(); check("stall_flags", {29'b0, zout, nout, cout}, 32'b110);
        check("stall_pc", pc, 32'h43);
        idle();

        // 32-bit wrap
        ex_valid = 1; branch = 1; alu_out = 32'hFFFF_FFFD;
        tick(); idle(); tick(); tick();
        check("pre_wrap", pc, 32'hFFFF_FFFF);
        ex_valid = 1; tick(); check("wrap", pc, 32'h0);
        tick(); tick(); tick(); check("post_wrap", pc, 32'd3);

        // Halt freezes until reset
        halt = 1; tick();
        check("halted", {31'b0, halted}, 32'd1); check("halt_flush", {31'b0, flush}, 32'd0);
        halt = 0; branch = 1; alu_out = 32'h55;
        for (int i = 0; i < 5; i++) begin
            tick(); check("halt_pc_frozen", pc, 32'd3);
        end
        rst = 1; tick(); check("halt_rst_pc", pc, RESET_PC);
        check("halt_rst_halted", {31'b0, halted}, 32'd0);
        idle();

        // Reset during second flush cycle
        ex_valid = 1; branch = 1; alu_out = 32'h100;
        tick(); idle(); tick();
        check("fl2_before_rst", pc, 32'h101);
        rst = 1; tick(); rst = 0;
        check("rst_fl_flush", {31'b0, flush}, 32'd0); check("rst_fl_pc", pc, RESET_PC);
        ex_valid = 1; tick(); check("rst_fl_run", pc, 32'd1);
        idle();

`ifdef PC_STATUS_CALL_STACK_EN
        // call/ret basic
        ex_valid = 1; branch = 1; alu_out = 32'h0E;
        tick(); idle(); tick(); tick(); check("at_0x10", pc, 32'h10);
        ex_valid = 1; call = 1; alu_out = 32'h80;
        tick(); check("call_pc", pc, 32'h80); idle(); tick(); tick();
        ex_valid = 1; ret = 1;
        tick(); check("ret_pc", pc, 32'h11); check("ret_flush", {31'b0, flush}, 32'd1);
        idle(); tick(); tick();
        // five calls overflow, five returns
        for (int i = 0; i < 5; i++) begin
            ex_valid = 1; call = 1; alu_out = 32'h200 + 32'(i) * 32'h10;
            tick(); idle(); tick(); tick();
        end
        ret_exp = '{32'h233, 32'h223, 32'h213, 32'h203, RESET_PC};
        for (int i = 0; i < 5; i++) begin
            ex_valid = 1; ret = 1;
            tick(); check("ret_seq", pc, ret_exp[i]);
            idle(); tick(); tick();
        end
`endif

        // Randomized traffic
        rst = 1; tick(); idle();
        for (int i = 0; i < 3000; i++) begin
            rst      = ($urandom_range(0, 39) == 0);
            stall    = ($urandom_range(0, 4) == 0);
            halt     = ($urandom_range(0, 79) == 0);
            ex_valid = ($urandom_range(0, 3) != 0);
            branch   = ($urandom_range(0, 3) == 0);
            call     = ($urandom_range(0, 11) == 0);
            ret      = ($urandom_range(0, 9) == 0);
            flag_we  = ($urandom_range(0, 1) == 0);
            alu_out  = $urandom();
            {z_in, n_in, c_in, v_in, h_in} = 5'($urandom());
            tick();
        end
        idle(); tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
